mt_scatter_decoder: RTL and testbench

- Reverse-direction partner of the redundancy controller: takes one dense output column plus its mapping-table (MT) column, and scatters dense values back to their original STEP_RANGE lane positions.
- Sits between the PE array output and the output-feature-map writer.
- Scans MT rows ROWS_PER_CYCLE at a time, detects mapping conflicts and uncovered lanes, and hands out the expanded column on a valid/ready handshake.

---
 rtl/mt_scatter_decoder.sv | 140 ++++++++++++++
 tb/tb_mt_scatter_decoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mt_scatter_decoder.sv
// Mapping-table scatter decoder: expands one dense column back onto its original
// lanes, scanning ROWS_PER_CYCLE MT rows per cycle; lowest row index wins a lane.
module mt_scatter_decoder #(
    parameter int WORD_WIDTH     = 8,
    parameter int STEP_RANGE     = 16,
    parameter int ROWS_PER_CYCLE = 4,
    parameter int SCAN_CNT_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH*STEP_RANGE-1:0] dense_column,
    input  logic [STEP_RANGE*STEP_RANGE-1:0] mt_column,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_WIDTH*STEP_RANGE-1:0] ofm_column,
    output logic [STEP_RANGE-1:0]            uncovered_mask,
    output logic                             conflict,
    output logic [1:0]                       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid is held with stable data until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [SCAN_CNT_WIDTH-1:0] LAST_GRP =
        SCAN_CNT_WIDTH'(STEP_RANGE / ROWS_PER_CYCLE - 1);

    state_t                             r_state;
    logic                               r_in_ready;
    logic                               r_out_valid;
    logic [SCAN_CNT_WIDTH-1:0]          r_scan_cnt;
    logic [WORD_WIDTH*STEP_RANGE-1:0]   r_dense;
    logic [STEP_RANGE*STEP_RANGE-1:0]   r_mt;
    logic [WORD_WIDTH*STEP_RANGE-1:0]   r_ofm;
    logic [STEP_RANGE-1:0]              r_claimed;
    logic                               r_conflict;

    logic [WORD_WIDTH*STEP_RANGE-1:0]   w_ofm_nxt;
    logic [STEP_RANGE-1:0]              w_claimed_nxt;
    logic                               w_conflict_nxt;

    // Rows are walked in ascending order so an earlier row has already claimed a lane
    // by the time a later row in the same group reaches it.
    always_comb begin
        w_ofm_nxt      = r_ofm;
        w_claimed_nxt  = r_claimed;
        w_conflict_nxt = r_conflict;
        for (int j = 0; j < STEP_RANGE; j++) begin
            if ((j / ROWS_PER_CYCLE) == int'(r_scan_cnt)) begin
                for (int i = 0; i < STEP_RANGE; i++) begin
                    if (r_mt[STEP_RANGE*j + i]) begin
                        if (w_claimed_nxt[i]) begin
                            w_conflict_nxt = 1'b1;
                        end else begin
                            w_ofm_nxt[WORD_WIDTH*i +: WORD_WIDTH] = r_dense[WORD_WIDTH*j +: WORD_WIDTH];
                            w_claimed_nxt[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_scan_cnt  <= '0;
            r_dense     <= '0;
            r_mt        <= '0;
            r_ofm       <= '0;
            r_claimed   <= '0;
            r_conflict  <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_scan_cnt  <= '0;
            r_dense     <= '0;
            r_mt        <= '0;
            r_ofm       <= '0;
            r_claimed   <= '0;
            r_conflict  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dense    <= dense_column;
                        r_mt       <= mt_column;
                        r_ofm      <= '0;
                        r_claimed  <= '0;
                        r_conflict <= 1'b0;
                        r_scan_cnt <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    r_ofm      <= w_ofm_nxt;
                    r_claimed  <= w_claimed_nxt;
                    r_conflict <= w_conflict_nxt;
                    r_scan_cnt <= r_scan_cnt + 1'b1;
                    if (r_scan_cnt == LAST_GRP) begin
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    // in_ready only rises after the output handshake edge, never in the same cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign ofm_column     = r_ofm;
    assign uncovered_mask = ~r_claimed;
    assign conflict       = r_conflict;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_mt_scatter_decoder.sv
// Directed bench for mt_scatter_decoder: a driver queues expected columns,
// an independent monitor pops and compares on every output handshake.
module tb_mt_scatter_decoder;

  localparam int WW = 8;
  localparam int SR = 16;

  typedef struct packed {
    logic [WW*SR-1:0] ofm;
    logic [SR-1:0]    unc;
    logic             conf;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WW*SR-1:0] dense_column = '0;
  logic [SR*SR-1:0] mt_column = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WW*SR-1:0] ofm_column;
  logic [SR-1:0]    uncovered_mask;
  logic             conflict;
  logic [1:0]       dbg_state;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc = 0;

  mt_scatter_decoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dense_column   (dense_column),
    .mt_column      (mt_column),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ofm_column     (ofm_column),
    .uncovered_mask (uncovered_mask),
    .conflict       (conflict),
    .dbg_state      (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WW*SR-1:0] act, input logic [WW*SR-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WW*SR-1:0] put_byte(input logic [WW*SR-1:0] v, input int idx, input logic [7:0] b);
    logic [WW*SR-1:0] r;
    r = v;
    r[WW*idx +: WW] = b;
    return r;
  endfunction

  function automatic logic [SR*SR-1:0] put_row(input logic [SR*SR-1:0] v, input int idx, input logic [SR-1:0] b);
    logic [SR*SR-1:0] r;
    r = v;
    r[SR*idx +: SR] = b;
    return r;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ofm_column", ofm_column, e.ofm);
        chk("uncovered_mask", {112'd0, uncovered_mask}, {112'd0, e.unc});
        chk("conflict", {127'd0, conflict}, {127'd0, e.conf});
      end
    end
  end

  // driver: present a column, wait (bounded) for acceptance
  task automatic send(input logic [WW*SR-1:0] d, input logic [SR*SR-1:0] m, input exp_t e);
    int n;
    n = 0;
    dense_column = d;
    mt_column = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  logic [WW*SR-1:0] d_id, d_fan, d_c1, d_c2, d_rev, d_zero;
  logic [SR*SR-1:0] m_id, m_fan, m_c1, m_c2, m_rev, m_zero;
  exp_t             e_id, e_fan, e_c1, e_c2, e_rev, e_zero;

  initial begin
    int acc1;
    // identity
    d_id = '0; m_id = '0; e_id = '0;
    for (int j = 0; j < SR; j++) begin
      d_id = put_byte(d_id, j, 8'(j + 1));
      m_id = put_row(m_id, j, 16'(1 << j));
      e_id.ofm = put_byte(e_id.ofm, j, 8'(j + 1));
    end
    e_id.unc = 16'h0000; e_id.conf = 1'b0;
    // fan-out; unused slots carry junk that must not leak
    d_fan = '0; m_fan = '0; e_fan = '0;
    for (int j = 0; j < SR; j++) d_fan = put_byte(d_fan, j, 8'(8'hC0 + j));
    d_fan = put_byte(d_fan, 0, 8'hAA);
    d_fan = put_byte(d_fan, 1, 8'h55);
    m_fan = put_row(m_fan, 0, 16'h000F);
    m_fan = put_row(m_fan, 1, 16'h00F0);
    for (int i = 0; i < 4; i++) e_fan.ofm = put_byte(e_fan.ofm, i, 8'hAA);
    for (int i = 4; i < 8; i++) e_fan.ofm = put_byte(e_fan.ofm, i, 8'h55);
    e_fan.unc = 16'hFF00; e_fan.conf = 1'b0;
    // conflict across groups: rows 2 and 9 on lane 5
    d_c1 = '0; m_c1 = '0; e_c1 = '0;
    d_c1 = put_byte(d_c1, 2, 8'h11);
    d_c1 = put_byte(d_c1, 9, 8'h22);
    m_c1 = put_row(m_c1, 2, 16'h0020);
    m_c1 = put_row(m_c1, 9, 16'h0020);
    e_c1.ofm = put_byte(e_c1.ofm, 5, 8'h11);
    e_c1.unc = 16'hFFDF; e_c1.conf = 1'b1;
    // conflict inside one group: rows 1 and 3 on lane 5
    d_c2 = '0; m_c2 = '0; e_c2 = '0;
    d_c2 = put_byte(d_c2, 1, 8'h33);
    d_c2 = put_byte(d_c2, 3, 8'h44);
    m_c2 = put_row(m_c2, 1, 16'h0020);
    m_c2 = put_row(m_c2, 3, 16'h0020);
    e_c2.ofm = put_byte(e_c2.ofm, 5, 8'h33);
    e_c2.unc = 16'hFFDF; e_c2.conf = 1'b1;
    // reversal permutation: row j -> lane 15-j
    d_rev = '0; m_rev = '0; e_rev = '0;
    for (int j = 0; j < SR; j++) begin
      d_rev = put_byte(d_rev, j, 8'(8'h80 + j));
      m_rev = put_row(m_rev, j, 16'(1 << (15 - j)));
      e_rev.ofm = put_byte(e_rev.ofm, 15 - j, 8'(8'h80 + j));
    end
    e_rev.unc = 16'h0000; e_rev.conf = 1'b0;
    // zero MT
    d_zero = '1; m_zero = '0; e_zero = '0;
    e_zero.unc = 16'hFFFF; e_zero.conf = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 1);
    chk("rst_out_valid", {127'd0, out_valid}, 0);
    chk("rst_ofm", ofm_column, 0);
    chk("rst_uncovered", {112'd0, uncovered_mask}, 128'hFFFF);
    chk("rst_conflict", {127'd0, conflict}, 0);
    chk("rst_state", {126'd0, dbg_state}, 0);
    @(posedge clk); #1;

    // basic function
    send(d_id, m_id, e_id);
    wait_drain();
    send(d_fan, m_fan, e_fan);
    wait_drain();
    send(d_c1, m_c1, e_c1);
    wait_drain();
    send(d_c2, m_c2, e_c2);
    wait_drain();
    send(d_zero, m_zero, e_zero);
    wait_drain();

    // back-to-back with out_ready tied high
    send(d_id, m_id, e_id);
    acc1 = last_acc;
    send(d_rev, m_rev, e_rev);
    chk("b2b_spacing", 128'(last_acc - acc1), 6);
    wait_drain();

    // backpressure, with a second column waiting on in_valid
    out_ready = 1'b0;
    send(d_fan, m_fan, e_fan);
    wait_out_valid();
    dense_column = d_c1;
    mt_column = m_c1;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {127'd0, out_valid}, 1);
      chk("bp_ofm_stable", ofm_column, e_fan.ofm);
      chk("bp_unc_stable", {112'd0, uncovered_mask}, {112'd0, e_fan.unc});
      chk("bp_in_ready", {127'd0, in_ready}, 0);
    end
    exp_q.push_back(e_c1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {127'd0, out_valid}, 0);
    chk("bp_release_in_ready", {127'd0, in_ready}, 1);
    @(posedge clk); #1;
    chk("bp_next_accepted", {126'd0, dbg_state}, 1);
    in_valid = 1'b0;
    wait_drain();

    // async reset mid-SCAN
    send(d_id, m_id, e_id);
    @(posedge clk); #1;
    chk("abort_rst_in_scan", {126'd0, dbg_state}, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_rst_out_valid", {127'd0, out_valid}, 0);
    chk("abort_rst_in_ready", {127'd0, in_ready}, 1);
    chk("abort_rst_unc", {112'd0, uncovered_mask}, 128'hFFFF);
    exp_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_rst_no_stale", {127'd0, out_valid}, 0);

    // synchronous clear during OUT
    out_ready = 1'b0;
    send(d_fan, m_fan, e_fan);
    wait_out_valid();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("abort_clr_out_valid", {127'd0, out_valid}, 0);
    chk("abort_clr_in_ready", {127'd0, in_ready}, 1);
    chk("abort_clr_unc", {112'd0, uncovered_mask}, 128'hFFFF);
    chk("abort_clr_ofm", ofm_column, 0);
    chk("abort_clr_conflict", {127'd0, conflict}, 0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_clr_no_stale", {127'd0, out_valid}, 0);

    // recovery after aborts
    send(d_rev, m_rev, e_rev);
    wait_drain();
    chk("final_queue_empty", 128'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
